instruction_memory_loadable: RTL and testbench

Parametrised, loadable, synchronous instruction memory for the MIPS core: successor to the fixed combinational instruction ROM. After reset, a LOAD phase fills the array over a sequential load port. A RUN phase serves fetches with one-cycle latency, an explicit valid flag, and a fault flag for misaligned or out-of-range addresses. It sits between the PC register and the instruction decoder; in a test harness, a boot/loader block drives the load port.

---
 rtl/imem_pkg.sv | 30 +++
 rtl/instruction_memory_loadable_storage.sv | 29 ++
 rtl/instruction_memory_loadable.sv | 107 ++++++++++
 tb/tb_instruction_memory_loadable.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory: phase enum,
// default fill word and the fetch address decode.
package imem_pkg;

  typedef enum logic {
    LOAD,
    RUN
  } state_e;

  localparam logic [31:0] DEFAULT_FILL_WORD = 32'hFFFF_FFFF;

  // Number of byte-offset bits inside one instruction word.
  function automatic int align_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Misaligned or beyond the array; the index compare is done in 33 bits so
  // large addresses never wrap back into range.
  function automatic logic fetch_fault(input logic [31:0] addr, input int depth,
                                       input int b);
    logic [31:0] mask;
    logic        misaligned;
    logic        out_of_range;
    mask         = (32'd1 << b) - 32'd1;
    misaligned   = (addr & mask) != 32'd0;
    out_of_range = {1'b0, addr >> b} >= 33'(depth);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/instruction_memory_loadable_storage.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// combinational read port.
module imem_storage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; stale words are masked by LoadCount in the
  // top level, which keeps this a plain register file.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: LOAD phase fills the array sequentially, RUN
// phase serves registered fetches with valid and fault flags.
module instruction_memory_loadable
  import imem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(DEFAULT_FILL_WORD)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       LoadEn,
  input  logic [DATA_WIDTH-1:0]      LoadData,
  input  logic                       LoadDone,
  output logic                       Ready,
  output logic [$clog2(DEPTH+1)-1:0] LoadCount,
  input  logic                       FetchReq,
  input  logic [31:0]                Address,
  output logic [DATA_WIDTH-1:0]      Word,
  output logic                       WordValid,
  output logic                       Fault
);

  localparam int B  = align_bits(DATA_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic                  ready_q, ready_d;
  logic                  load_fire;
  logic                  fetch_bad;
  logic [31:0]           idx;
  logic [DATA_WIDTH-1:0] rdata;

  imem_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_storage (
    .clk  (Clk),
    .we   (load_fire),
    .waddr(count_q[AW-1:0]),
    .wdata(LoadData),
    .raddr(idx[AW-1:0]),
    .rdata(rdata)
  );

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    word_d    = word_q;
    fault_d   = fault_q;
    valid_d   = 1'b0;
    idx       = Address >> B;
    fetch_bad = fetch_fault(Address, DEPTH, B);
    load_fire = (state_q == LOAD) && LoadEn && (count_q < CW'(DEPTH));

    if (load_fire) count_d = count_q + CW'(1);

    // The final word and LoadDone both leave LOAD on the same edge as any write.
    if ((state_q == LOAD) &&
        (LoadDone || (load_fire && (count_q == CW'(DEPTH - 1))))) begin
      state_d = RUN;
    end

    if ((state_q == RUN) && FetchReq) begin
      valid_d = 1'b1;
      fault_d = fetch_bad;
      word_d  = (fetch_bad || ({1'b0, idx} >= 33'(count_q))) ? FILL_WORD : rdata;
    end

    ready_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= LOAD;
      count_q <= '0;
      word_q  <= FILL_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      ready_q <= ready_d;
    end
  end

  assign Ready     = ready_q;
  assign LoadCount = count_q;
  assign Word      = word_q;
  assign WordValid = valid_q;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable: a 32-bit and a 64-bit
// instance, both DEPTH=8, driven through a linear sequence of steps.
module tb_instruction_memory_loadable;

  localparam logic [31:0] FILL32 = 32'hFFFF_FFFF;
  localparam logic [63:0] FILL64 = 64'h0000_0000_FFFF_FFFF;

  logic        clk;
  int          n_assert;
  int          n_fail;

  // 32-bit instance
  logic        rst, load_en, load_done, fetch_req;
  logic [31:0] load_data, address;
  logic        ready, word_valid, fault;
  logic [3:0]  load_count;
  logic [31:0] word;

  // 64-bit instance
  logic        rst64, load_en64, load_done64, fetch_req64;
  logic [63:0] load_data64;
  logic [31:0] address64;
  logic        ready64, word_valid64, fault64;
  logic [3:0]  load_count64;
  logic [63:0] word64;

  instruction_memory_loadable #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .Clk(clk), .Reset(rst), .LoadEn(load_en), .LoadData(load_data),
    .LoadDone(load_done), .Ready(ready), .LoadCount(load_count),
    .FetchReq(fetch_req), .Address(address), .Word(word),
    .WordValid(word_valid), .Fault(fault)
  );

  instruction_memory_loadable #(.DATA_WIDTH(64), .DEPTH(8)) dut64 (
    .Clk(clk), .Reset(rst64), .LoadEn(load_en64), .LoadData(load_data64),
    .LoadDone(load_done64), .Ready(ready64), .LoadCount(load_count64),
    .FetchReq(fetch_req64), .Address(address64), .Word(word64),
    .WordValid(word_valid64), .Fault(fault64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch32(input logic [31:0] a, input logic [31:0] exp_word,
                         input logic exp_fault, input string tag);
    fetch_req = 1'b1;
    address   = a;
    tick();
    fetch_req = 1'b0;
    check({tag, " valid"}, 64'(word_valid), 64'd1);
    check({tag, " word"},  64'(word), 64'(exp_word));
    check({tag, " fault"}, 64'(fault), 64'(exp_fault));
  endtask

  task automatic fetch64(input logic [31:0] a, input logic [63:0] exp_word,
                         input logic exp_fault, input string tag);
    fetch_req64 = 1'b1;
    address64   = a;
    tick();
    fetch_req64 = 1'b0;
    check({tag, " valid"}, 64'(word_valid64), 64'd1);
    check({tag, " word"},  word64, exp_word);
    check({tag, " fault"}, 64'(fault64), 64'(exp_fault));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; load_en = 1'b0; load_done = 1'b0; fetch_req = 1'b0;
    load_data = '0; address = '0;
    rst64 = 1'b1; load_en64 = 1'b0; load_done64 = 1'b0; fetch_req64 = 1'b0;
    load_data64 = '0; address64 = '0;

    tick();
    check("rst ready", 64'(ready), 64'd0);
    check("rst count", 64'(load_count), 64'd0);
    check("rst word",  64'(word), 64'(FILL32));
    check("rst valid", 64'(word_valid), 64'd0);
    check("rst fault", 64'(fault), 64'd0);
    check("rst64 word", word64, FILL64);
    rst = 1'b0;
    tick();

    // Full load without LoadDone; fetches during LOAD must be ignored.
    fetch_req = 1'b1;
    address   = 32'h0;
    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_data = 32'h1000_0000 + 32'(i);
      tick();
      check($sformatf("full cnt%0d", i), 64'(load_count), 64'(i + 1));
      check($sformatf("full rdy%0d", i), 64'(ready), 64'(i == 7));
      check($sformatf("full val%0d", i), 64'(word_valid), 64'd0);
    end
    fetch_req = 1'b0;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    check("full ignore load", 64'(load_count), 64'd8);

    // Back-to-back fetches, one per cycle.
    fetch_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 32'(i * 4);
      tick();
      check($sformatf("b2b val%0d", i), 64'(word_valid), 64'd1);
      check($sformatf("b2b word%0d", i), 64'(word), 64'(32'h1000_0000 + 32'(i)));
      check($sformatf("b2b flt%0d", i), 64'(fault), 64'd0);
    end
    fetch_req = 1'b0;
    tick();
    check("idle valid", 64'(word_valid), 64'd0);
    check("idle hold",  64'(word), 64'h1000_0007);

    fetch32(32'h0000_0002, FILL32, 1'b1, "misaligned");
    fetch32(32'h0000_0020, FILL32, 1'b1, "oor 0x20");
    fetch32(32'h8000_0000, FILL32, 1'b1, "oor nowrap");
    fetch32(32'h0000_001C, 32'h1000_0007, 1'b0, "last word");

    // Reset with a fetch in flight.
    fetch_req = 1'b1;
    address   = 32'h4;
    tick();
    check("inflight valid", 64'(word_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst valid", 64'(word_valid), 64'd0);
    check("midrst ready", 64'(ready), 64'd0);
    check("midrst count", 64'(load_count), 64'd0);
    fetch_req = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("reload ready", 64'(ready), 64'd1);
    check("reload count", 64'(load_count), 64'd0);
    fetch32(32'h0, FILL32, 1'b0, "stale word");

    // Partial load then LoadDone.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_en   = 1'b1;
      load_data = 32'h2000_0000 + 32'(i);
      tick();
    end
    load_en = 1'b0;
    check("part ready pre", 64'(ready), 64'd0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("part ready", 64'(ready), 64'd1);
    check("part count", 64'(load_count), 64'd3);
    fetch32(32'h08, 32'h2000_0002, 1'b0, "part word2");
    fetch32(32'h0C, FILL32, 1'b0, "part unloaded");

    // LoadEn and LoadDone together at LoadCount=4.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_en   = 1'b1;
      load_data = 32'h3000_0000 + 32'(i);
      tick();
    end
    load_data = 32'h3000_0004;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("sim count", 64'(load_count), 64'd5);
    check("sim ready", 64'(ready), 64'd1);
    load_data = 32'hCAFE_0000;
    tick();
    load_en = 1'b0;
    check("sim ignore", 64'(load_count), 64'd5);
    fetch32(32'h10, 32'h3000_0004, 1'b0, "sim word4");
    fetch32(32'h14, FILL32, 1'b0, "sim word5");

    // 64-bit instance.
    rst64 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      load_en64   = 1'b1;
      load_data64 = 64'hA5A5_0000_0000_0000 + 64'(i);
      tick();
    end
    load_en64   = 1'b0;
    load_done64 = 1'b1;
    tick();
    load_done64 = 1'b0;
    check("w64 ready", 64'(ready64), 64'd1);
    fetch64(32'h04, FILL64, 1'b1, "w64 misaligned");
    fetch64(32'h08, 64'hA5A5_0000_0000_0001, 1'b0, "w64 word1");
    fetch64(32'h38, FILL64, 1'b0, "w64 unloaded");
    fetch64(32'h40, FILL64, 1'b1, "w64 oor");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
